// File: rtl/im_loader.sv
// rtl/im_loader.sv - boot-time byte-stream to instruction-memory word writer
//
// Assembles a big-endian byte stream into 32-bit words and writes them to
// consecutive instruction-memory words starting at BASE_ADDR. The CPU is held
// until the word carrying the last byte has been committed.
//
// Ports:
//   clk, reset            clock, asynchronous active-high reset
//   in_valid/in_data/in_last/in_ready   byte stream handshake
//   im_we/im_addr/im_wdata              one-cycle memory write port
//   cpu_hold              holds the fetch PC at BASE_ADDR while 1
//   load_done             image fully committed
//   overflow              sticky, a word was dropped because memory was full
//   word_count            number of words actually written
module im_loader #(
  parameter logic [31:0] BASE_ADDR = 32'h00003000,
  parameter int          IM_SIZE   = 1024,
  parameter int          CW        = 11
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          in_valid,
  input  logic [7:0]    in_data,
  input  logic          in_last,
  output logic          in_ready,
  output logic          im_we,
  output logic [31:0]   im_addr,
  output logic [31:0]   im_wdata,
  output logic          cpu_hold,
  output logic          load_done,
  output logic          overflow,
  output logic [CW-1:0] word_count
);

  typedef enum logic [1:0] {S_LOAD, S_WRITE, S_DONE} state_t;

  state_t        state;
  state_t        state_next;
  logic [1:0]    byte_cnt;
  logic [31:0]   acc;
  logic [CW-1:0] word_idx;
  logic          last_seen;

  logic          take;
  logic          word_end;
  logic          mem_full;
  logic [31:0]   acc_next;

  // Handshake decoded from state only, so no in_valid -> in_ready path.
  assign take     = in_valid && (state == S_LOAD);
  assign word_end = take && ((byte_cnt == 2'd3) || in_last);
  assign mem_full = (word_idx == CW'(IM_SIZE));

  // Byte k lands at [31-8k:24-8k]; acc is cleared after every word, so the
  // unfilled low bytes of a short final word read as zero.
  assign acc_next = acc | ({in_data, 24'h000000} >> {byte_cnt, 3'b000});

  assign word_count = word_idx;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_LOAD;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    im_we      = 1'b0;
    cpu_hold   = 1'b1;
    load_done  = 1'b0;
    case (state)
      S_LOAD: begin
        in_ready = 1'b1;
        if (word_end) begin
          // A full memory skips the write; only the last byte ends the load.
          if (!mem_full) begin
            state_next = S_WRITE;
          end else if (in_last) begin
            state_next = S_DONE;
          end
        end
      end
      S_WRITE: begin
        im_we      = 1'b1;
        state_next = last_seen ? S_DONE : S_LOAD;
      end
      S_DONE: begin
        cpu_hold  = 1'b0;
        load_done = 1'b1;
      end
      default: begin
        state_next = S_LOAD;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      byte_cnt  <= 2'd0;
      acc       <= 32'h0;
      word_idx  <= '0;
      last_seen <= 1'b0;
      im_addr   <= BASE_ADDR;
      im_wdata  <= 32'h0;
      overflow  <= 1'b0;
    end else begin
      if (take) begin
        if (word_end) begin
          byte_cnt  <= 2'd0;
          acc       <= 32'h0;
          last_seen <= in_last;
          if (!mem_full) begin
            im_wdata <= acc_next;
            im_addr  <= BASE_ADDR + 32'({word_idx, 2'b00});
          end else begin
            overflow <= 1'b1;
          end
        end else begin
          byte_cnt <= byte_cnt + 2'd1;
          acc      <= acc_next;
        end
      end
      if (state == S_WRITE) begin
        word_idx <= word_idx + CW'(1);
      end
    end
  end

endmodule
